// File: rtl/mem_pkg.sv
// Shared types for the byte-wide memory master: FSM state encoding and access width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    ACC_BYTE = 1'b0,
    ACC_WORD = 1'b1
  } acc_width_e;

  localparam int BUS_W  = 8;
  localparam int DATA_W = 16;

  function automatic acc_width_e width_of(input logic wide);
    return wide ? ACC_WORD : ACC_BYTE;
  endfunction

endpackage

// File: rtl/mem_master.sv
// Request/response master for an 8-bit shared-bus memory; 16-bit accesses are split
// into two little-endian byte cycles.
//
//   state  | meaning
//   IDLE   | waiting for a request, req_ready high
//   ACC_LO | low-byte access at the latched address
//   ACC_HI | high-byte access at address+1 (16-bit only)
//   RESP   | one-cycle resp_valid pulse
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              RE,
  output logic              WE,
  inout  wire  [7:0]        databus
);

  state_e            state_q, state_d;
  logic              lat_we;
  acc_width_e        lat_width;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic [7:0]        rd_lo;
  logic [7:0]        drive_byte;

  // Memory-side pins come only from state_q and the latched request fields.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    RE         = 1'b0;
    WE         = 1'b0;
    drive_byte = lat_wdata[7:0];
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACC_LO;
      end
      ACC_LO: begin
        RE      = !lat_we;
        WE      = lat_we;
        state_d = (lat_width == ACC_WORD) ? ACC_HI : RESP;
      end
      ACC_HI: begin
        RE         = !lat_we;
        WE         = lat_we;
        drive_byte = lat_wdata[15:8];
        state_d    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign databus = WE ? drive_byte : 8'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_we     <= 1'b0;
      lat_width  <= ACC_BYTE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rd_lo      <= '0;
      address    <= '0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_width <= width_of(req_wide);
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            address   <= req_addr;
          end
        end
        ACC_LO: begin
          if (lat_width == ACC_WORD) begin
            address <= lat_addr + ADDR_W'(1);
            if (!lat_we) rd_lo <= databus;
          end else if (!lat_we) begin
            resp_rdata <= {8'h00, databus};
          end
        end
        ACC_HI: begin
          if (!lat_we) resp_rdata <= {databus, rd_lo};
        end
        default: ;
      endcase
    end
  end

  a_re_we_excl: assert property (@(posedge clk) !(RE && WE));
  a_resp_pulse: assert property (@(posedge clk) disable iff (rst) resp_valid |=> !resp_valid);

endmodule
